icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 24 ++
 rtl/icache_array.sv | 53 +++++
 rtl/icache.sv | 126 ++++++++++++
 tb/tb_icache.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-split constants for the direct-mapped instruction cache.
// Optional performance counters are enabled with the ICACHE_PERF_EN macro (see icache.sv).
package icache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_e;

    localparam int ADDR_BITS        = 32;
    localparam int WORD_BITS        = 32;
    localparam int OFFSET_BITS      = 3;   // word select within a line
    localparam int LINE_OFFSET_BITS = 5;   // byte offset within a line
    localparam int LINE_ADDR_BITS   = ADDR_BITS - LINE_OFFSET_BITS;

    function automatic int index_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int num_sets);
        return ADDR_BITS - LINE_OFFSET_BITS - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped icache with combinational hit compare.
// Only the valid bits are reset; tag and data contents are meaningless until a fill sets valid.
module icache_array
    import icache_pkg::*;
#(
    parameter int NUM_SETS  = 16,
    parameter int LINE_BITS = 256,
    localparam int IDX_W    = index_bits(NUM_SETS),
    localparam int TAG_W    = tag_bits(NUM_SETS),
    localparam int WORDS    = LINE_BITS / WORD_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IDX_W-1:0]       rd_index,
    input  logic [TAG_W-1:0]       rd_tag,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    output logic                   rd_hit,
    output logic [WORD_BITS-1:0]   rd_word,
    input  logic                   inv_all,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_index,
    input  logic [TAG_W-1:0]       wr_tag,
    input  logic [LINE_BITS-1:0]   wr_line,
    input  logic                   wr_valid
);

    logic [NUM_SETS-1:0]                 valid_q;
    logic [TAG_W-1:0]                    tag_mem  [NUM_SETS];
    logic [WORDS-1:0][WORD_BITS-1:0]     data_mem [NUM_SETS];

    // A fill landing in the same cycle as an invalidate writes wr_valid=0, so it stays cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (inv_all) valid_q <= '0;
            if (wr_en)   valid_q[wr_index] <= wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_line;
        end
    end

    always_comb begin
        rd_hit  = valid_q[rd_index] && (tag_mem[rd_index] == rd_tag);
        rd_word = data_mem[rd_index][rd_offset];
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: IDLE/FILL controller, fill-address latch, optional counters.
// Define ICACHE_PERF_EN to add saturating hit_count/miss_count outputs.
module icache
    import icache_pkg::*;
#(
    parameter int NUM_SETS  = 16,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 imem_read,
    input  logic [31:0]          imem_address,
    output logic [31:0]          imem_rdata,
    output logic                 imem_resp,
    input  logic                 inv,
    output logic                 pmem_read,
    output logic [31:0]          pmem_address,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp,
`ifdef ICACHE_PERF_EN
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count,
`endif
    output icache_state_e        state_dbg
);

    localparam int IDX_W = index_bits(NUM_SETS);
    localparam int TAG_W = tag_bits(NUM_SETS);

    // Handshake: imem_read is a level request; imem_resp/imem_rdata are valid for that cycle only.
    // pmem_read stays high with a stable address until the one-cycle pmem_resp strobe.
    icache_state_e             state_q, state_d;
    logic [LINE_ADDR_BITS-1:0] fill_line_q;
    logic                      inv_pend_q;
    logic                      arr_hit;
    logic [WORD_BITS-1:0]      arr_word;
    logic                      start_fill;
    logic                      fill_we;
    logic                      unused_addr_bits;

    assign unused_addr_bits = ^imem_address[1:0];
    assign state_dbg        = state_q;

    icache_array #(
        .NUM_SETS  (NUM_SETS),
        .LINE_BITS (LINE_BITS)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_index  (imem_address[LINE_OFFSET_BITS +: IDX_W]),
        .rd_tag    (imem_address[ADDR_BITS-1 -: TAG_W]),
        .rd_offset (imem_address[LINE_OFFSET_BITS-1:2]),
        .rd_hit    (arr_hit),
        .rd_word   (arr_word),
        .inv_all   (inv),
        .wr_en     (fill_we),
        .wr_index  (fill_line_q[IDX_W-1:0]),
        .wr_tag    (fill_line_q[LINE_ADDR_BITS-1 -: TAG_W]),
        .wr_line   (pmem_rdata),
        .wr_valid  (!(inv_pend_q || inv))
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // An invalidate cycle in IDLE suppresses the lookup; the request is re-evaluated next cycle.
    always_comb begin
        state_d      = state_q;
        imem_resp    = 1'b0;
        pmem_read    = 1'b0;
        pmem_address = '0;
        start_fill   = 1'b0;
        fill_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (imem_read && !inv) begin
                    if (arr_hit) begin
                        imem_resp = 1'b1;
                    end else begin
                        start_fill = 1'b1;
                        state_d    = FILL;
                    end
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {fill_line_q, {LINE_OFFSET_BITS{1'b0}}};
                if (pmem_resp) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_rdata = imem_resp ? arr_word : '0;

    // inv_pend_q remembers an invalidate seen earlier in the fill so the landing line stays invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_line_q <= '0;
            inv_pend_q  <= 1'b0;
        end else if (start_fill) begin
            fill_line_q <= imem_address[ADDR_BITS-1:LINE_OFFSET_BITS];
            inv_pend_q  <= 1'b0;
        end else if (state_q == FILL && inv) begin
            inv_pend_q  <= 1'b1;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (imem_resp && hit_count != 32'hFFFF_FFFF)   hit_count  <= hit_count + 32'd1;
            if (start_fill && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus a randomized phase against an array model.
module tb_icache;
    import icache_pkg::*;

    localparam int NUM_SETS  = 16;
    localparam int LINE_BITS = 256;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 imem_read = 1'b0;
    logic [31:0]          imem_address = '0;
    logic [31:0]          imem_rdata;
    logic                 imem_resp;
    logic                 inv = 1'b0;
    logic                 pmem_read;
    logic [31:0]          pmem_address;
    logic [LINE_BITS-1:0] pmem_rdata = '0;
    logic                 pmem_resp = 1'b0;
    icache_state_e        state_dbg;
`ifdef ICACHE_PERF_EN
    logic [31:0]          hit_count;
    logic [31:0]          miss_count;
`endif

    icache #(
        .NUM_SETS  (NUM_SETS),
        .LINE_BITS (LINE_BITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .inv          (inv),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
`ifdef ICACHE_PERF_EN
        .hit_count    (hit_count),
        .miss_count   (miss_count),
`endif
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    // Reference model: a table of lines indexed by plain address arithmetic.
    bit              m_valid [NUM_SETS];
    int unsigned     m_tag   [NUM_SETS];
    logic [255:0]    m_line  [NUM_SETS];
    logic [31:0]     exp_q[$];
    int unsigned     exp_hits = 0;
    int unsigned     exp_misses = 0;
    int              n_cmp = 0;
    int              n_err = 0;
    logic [255:0]    line_a;

    function automatic int unsigned set_of(input logic [31:0] a);
        return (a / 32) % NUM_SETS;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a / (32 * NUM_SETS);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[set_of(a)] && (m_tag[set_of(a)] == tag_of(a));
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [255:0] l;
        l = m_line[set_of(a)];
        return l[((a % 32) / 4) * 32 +: 32];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NUM_SETS; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_counters(input string tag);
`ifdef ICACHE_PERF_EN
        check({tag, "_hit_count"}, hit_count, exp_hits);
        check({tag, "_miss_count"}, miss_count, exp_misses);
`else
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
`endif
    endtask

    task automatic settle();
        @(negedge clk);
        imem_read = 1'b0;
        #1;
    endtask

    // One request: checks the lookup cycle, every FILL cycle and the cycle after a fill.
    task automatic fetch(input logic [31:0] addr, input logic [255:0] line, input int delay,
                         input logic [31:0] mid_addr, input bit inv_mid);
        bit hit;
        @(negedge clk);
        imem_read    = 1'b1;
        imem_address = addr;
        #1;
        hit = model_hit(addr);
        check("lookup_resp", imem_resp, hit);
        check("lookup_pmem_read", pmem_read, 0);
        if (hit) begin
            exp_hits++;
            exp_q.push_back(model_word(addr));
            check("hit_rdata", imem_rdata, exp_q.pop_front());
        end else begin
            check("miss_rdata", imem_rdata, 0);
            exp_misses++;
            for (int k = 0; k <= delay; k++) begin
                @(negedge clk);
                imem_address = mid_addr;
                imem_read    = 1'($urandom_range(0, 1));
                inv          = inv_mid && (k == 0);
                if (k == delay) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = line;
                end
                #1;
                check("fill_pmem_read", pmem_read, 1);
                check("fill_pmem_addr", pmem_address, addr & ~32'h1F);
                check("fill_resp", imem_resp, 0);
            end
            if (inv_mid) begin
                model_clear();
            end else begin
                m_valid[set_of(addr)] = 1'b1;
                m_tag[set_of(addr)]   = tag_of(addr);
                m_line[set_of(addr)]  = line;
            end
            @(negedge clk);
            pmem_resp    = 1'b0;
            inv          = 1'b0;
            pmem_rdata   = rand_line();
            imem_read    = 1'b1;
            imem_address = addr;
            #1;
            hit = model_hit(addr);
            check("post_fill_resp", imem_resp, hit);
            check("post_fill_pmem_read", pmem_read, 0);
            if (hit) begin
                exp_hits++;
                exp_q.push_back(model_word(addr));
                check("post_fill_rdata", imem_rdata, exp_q.pop_front());
            end else begin
                check("post_fill_rdata_zero", imem_rdata, 0);
                imem_read = 1'b0;
            end
        end
    endtask

    // Invalidate pulse while presenting a read; the response must be suppressed that cycle.
    task automatic do_inv(input logic [31:0] addr);
        @(negedge clk);
        imem_read    = 1'b1;
        imem_address = addr;
        inv          = 1'b1;
        #1;
        check("inv_resp", imem_resp, 0);
        check("inv_rdata", imem_rdata, 0);
        model_clear();
        @(negedge clk);
        inv       = 1'b0;
        imem_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        model_clear();

        // Reset values
        #3;
        check("reset_resp", imem_resp, 0);
        check("reset_rdata", imem_rdata, 0);
        check("reset_pmem_read", pmem_read, 0);
        check("reset_pmem_addr", pmem_address, 0);
        check("reset_state", 32'(state_dbg), 32'(IDLE));
        check_counters("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss, fill with word0 = addi x0,x0,0
        line_a = rand_line();
        line_a[31:0] = 32'h0000_0013;
        fetch(32'h4000_0000, line_a, 2, 32'h4000_0000, 1'b0);
        check("first_word", imem_rdata, 32'h0000_0013);

        // Same-line hits, last word first
        fetch(32'h4000_001C, '0, 0, 32'h0, 1'b0);
        check("last_word", imem_rdata, line_a[255:224]);
        for (int w = 1; w < 7; w++) fetch(32'h4000_0000 + 32'(w * 4), '0, 0, 32'h0, 1'b0);
        settle();
        check_counters("seq_hits");
`ifdef ICACHE_PERF_EN
        check("seq_hit_count_8", hit_count, 32'd8);
        check("seq_miss_count_1", miss_count, 32'd1);
`endif

        // Conflict on index 0, then the evicted line misses again
        fetch(32'h4000_0200, rand_line(), 1, 32'h4000_0200, 1'b0);
        fetch(32'h4000_0000, line_a, 0, 32'h4000_0000, 1'b0);

        // Address moves mid-fill; the fill must keep the original line
        fetch(32'h4000_0040, rand_line(), 3, 32'h4000_0100, 1'b0);
        fetch(32'h4000_0100, rand_line(), 1, 32'h4000_0100, 1'b0);

        // Invalidate then re-read; invalidate during a fill
        do_inv(32'h4000_0000);
        fetch(32'h4000_0000, line_a, 1, 32'h4000_0000, 1'b0);
        fetch(32'h4000_0080, rand_line(), 2, 32'h4000_0080, 1'b1);
        fetch(32'h4000_0000, line_a, 0, 32'h4000_0000, 1'b0);
        fetch(32'h4000_00A0, rand_line(), 0, 32'h4000_00A0, 1'b1);

        // pmem_resp while IDLE must not disturb the array
        @(negedge clk);
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
        @(negedge clk);
        pmem_resp  = 1'b0;
        fetch(32'h4000_0008, '0, 0, 32'h0, 1'b0);

        // Randomized traffic over four tags, including ignored byte-offset bits
        for (int n = 0; n < 60; n++) begin
            addr = 32'h4000_0000 + (32'($urandom_range(0, 3)) << 9) + (32'($urandom_range(0, 15)) << 5)
                 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) do_inv(addr);
            fetch(addr, rand_line(), $urandom_range(0, 3), $urandom, ($urandom_range(0, 7) == 0));
        end
        settle();
        check_counters("random");

        // Reset asserted mid-fill, then a stale pmem_resp
        addr = 32'h4000_0300;
        @(negedge clk);
        imem_read    = 1'b1;
        imem_address = addr;
        #1;
        check("rst_pre_lookup", imem_resp, model_hit(addr));
        if (model_hit(addr)) do_inv(addr);
        @(negedge clk);
        imem_read = 1'b1;
        @(negedge clk);
        #1;
        check("rst_in_fill", pmem_read, 1);
        @(negedge clk);
        rst_n     = 1'b0;
        imem_read = 1'b0;
        #1;
        model_clear();
        exp_hits   = 0;
        exp_misses = 0;
        check("rst_pmem_read", pmem_read, 0);
        check("rst_pmem_addr", pmem_address, 0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check_counters("rst_mid_fill");
        @(negedge clk);
        rst_n      = 1'b1;
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
        @(negedge clk);
        pmem_resp  = 1'b0;
        #1;
        check("late_resp_state", 32'(state_dbg), 32'(IDLE));
        check("late_resp_pmem_read", pmem_read, 0);
        fetch(addr, rand_line(), 1, addr, 1'b0);
        settle();
        check_counters("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
